brightness_level_ctrl: RTL and testbench

Sequences the 3-bit `freq_flag` level that drives `brightness_filter`. Level requests come from the audio/frequency detection path. Each request is debounced over whole video frames, then the filter level is stepped one unit per frame boundary toward the target, with a minimum dwell between steps. The filter level never changes mid-frame, which prevents tearing. Sits between the frequency-detect logic and the brightness filter, in the `clk` domain.

---
 rtl/brightness_level_ctrl_pkg.sv | 20 ++
 rtl/brightness_level_ctrl_frame_event_counter.sv | 30 +++
 rtl/brightness_level_ctrl.sv | 148 ++++++++++++++
 tb/tb_brightness_level_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/brightness_level_ctrl_pkg.sv
// Shared types, default constants and helpers for the brightness level sequencer.
package brightness_pkg;

    typedef enum logic [1:0] {
        IDLE,
        QUALIFY,
        RAMP,
        DWELL
    } state_t;

    localparam int unsigned LEVEL_W_DEF   = 3;
    localparam int unsigned MAX_LEVEL_DEF = 4;

    // Limit a requested level to the highest legal filter level.
    function automatic int unsigned clamp_level(input int unsigned level,
                                                input int unsigned max_level);
        return (level > max_level) ? max_level : level;
    endfunction

endpackage

// File: rtl/brightness_level_ctrl_frame_event_counter.sv
// 4-bit saturating counter of frame events with synchronous clear and a
// terminal-count flag; used for both the debounce and the dwell intervals.
module frame_event_counter #(
    parameter int unsigned LIMIT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic done
);

    localparam logic [3:0] LIMIT_V = 4'(LIMIT);

    logic [3:0] count;

    // Clear has priority; the count sticks at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 4'd1;
        end
    end

    assign done = (count == LIMIT_V);

endmodule

// File: rtl/brightness_level_ctrl.sv
// Frame-synchronous sequencer for the brightness filter level: debounces level
// requests over whole frames, then steps freq_flag one unit per frame boundary
// toward the target with a dwell between steps.
module brightness_level_ctrl
    import brightness_pkg::*;
#(
    parameter int unsigned LEVEL_W      = LEVEL_W_DEF,
    parameter int unsigned MAX_LEVEL    = MAX_LEVEL_DEF,
    parameter int unsigned HOLD_FRAMES  = 2,
    parameter int unsigned DWELL_FRAMES = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               freq_valid,
    input  logic [LEVEL_W-1:0] freq_level,
    input  logic               frame_start,
    output logic [LEVEL_W-1:0] freq_flag,
    output logic               level_changed,
    output logic               busy
);

    state_t             state;
    logic               frame_d;
    logic               frame_evt;
    logic               req;
    logic               q_clear;
    logic               q_done;
    logic               d_clear;
    logic               d_done;
    logic [LEVEL_W-1:0] req_val;
    logic [LEVEL_W-1:0] target;
    logic [LEVEL_W-1:0] tgt_n;

    assign req_val = LEVEL_W'(clamp_level(32'(freq_level), MAX_LEVEL));

    // Rising-edge detect so a stretched frame_start counts once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_d <= 1'b0;
        end else begin
            frame_d <= frame_start;
        end
    end

    // Effective target this cycle and counter clear controls.
    always_comb begin
        req       = enable && freq_valid;
        frame_evt = frame_start && !frame_d;
        if (!enable) begin
            tgt_n = '0;
        end else if (freq_valid) begin
            tgt_n = req_val;
        end else begin
            tgt_n = target;
        end
        // A differing request restarts debounce; a coincident frame is not counted.
        q_clear = (state != QUALIFY) || (req && (req_val != target));
        d_clear = (state != DWELL);
    end

    frame_event_counter #(.LIMIT(HOLD_FRAMES)) u_qual_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (q_clear),
        .inc   (frame_evt),
        .done  (q_done)
    );

    frame_event_counter #(.LIMIT(DWELL_FRAMES)) u_dwell_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (d_clear),
        .inc   (frame_evt),
        .done  (d_done)
    );

    // Level sequencer FSM; all outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            freq_flag     <= '0;
            target        <= '0;
            level_changed <= 1'b0;
            busy          <= 1'b0;
        end else begin
            level_changed <= 1'b0;
            target        <= tgt_n;
            case (state)
                IDLE: begin
                    if (!enable) begin
                        if (freq_flag != '0) begin
                            state <= RAMP;
                            busy  <= 1'b1;
                        end
                    end else if (freq_valid && (req_val != freq_flag)) begin
                        state <= QUALIFY;
                        busy  <= 1'b1;
                    end
                end
                QUALIFY: begin
                    if (!enable) begin
                        if (freq_flag != '0) begin
                            state <= RAMP;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else if (freq_valid && (req_val == freq_flag)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (freq_valid && (req_val != target)) begin
                        state <= QUALIFY;
                    end else if (q_done) begin
                        state <= RAMP;
                    end
                end
                RAMP: begin
                    if (tgt_n == freq_flag) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (frame_evt) begin
                        freq_flag     <= (tgt_n > freq_flag) ? freq_flag + LEVEL_W'(1)
                                                             : freq_flag - LEVEL_W'(1);
                        level_changed <= 1'b1;
                        state         <= DWELL;
                    end
                end
                DWELL: begin
                    // Disable while dwelling keeps the dwell; the target is already 0.
                    if (d_done) begin
                        if (tgt_n == freq_flag) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= RAMP;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_brightness_level_ctrl.sv
// Self-checking bench for brightness_level_ctrl: directed scenarios plus a
// randomized run against a frame-level behavioural model.
module tb_brightness_level_ctrl;

    localparam int HOLD  = 2;
    localparam int DWELL = 1;
    localparam int MAXL  = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       freq_valid;
    logic [2:0] freq_level;
    logic       frame_start;
    logic [2:0] freq_flag;
    logic       level_changed;
    logic       busy;

    int checks   = 0;
    int fails    = 0;
    int lc_count = 0;

    // Frame-level model: current level, target, busy, debounce phase, frames left.
    int m_flag, m_tgt, m_left;
    bit m_busy, m_qual;

    brightness_level_ctrl #(
        .LEVEL_W      (3),
        .MAX_LEVEL    (MAXL),
        .HOLD_FRAMES  (HOLD),
        .DWELL_FRAMES (DWELL)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .freq_valid    (freq_valid),
        .freq_level    (freq_level),
        .frame_start   (frame_start),
        .freq_flag     (freq_flag),
        .level_changed (level_changed),
        .busy          (busy)
    );

    always #10 clk = ~clk;

    always @(posedge clk) if (level_changed === 1'b1) lc_count++;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1);
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame(input int hi);
        @(negedge clk);
        frame_start = 1'b1;
        repeat (hi) @(negedge clk);
        frame_start = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic request(input logic [2:0] lvl);
        @(negedge clk);
        freq_valid = 1'b1;
        freq_level = lvl;
        @(negedge clk);
        freq_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset       = 1'b1;
        freq_valid  = 1'b0;
        frame_start = 1'b0;
        cycles(2);
        reset = 1'b0;
        cycles(1);
    endtask

    task automatic model_frame(output int stepped);
        stepped = 0;
        if (m_busy) begin
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    if (m_qual) m_qual = 0;
                    else if (m_flag == m_tgt) m_busy = 0;
                end
            end else begin
                m_flag  = m_flag + ((m_tgt > m_flag) ? 1 : -1);
                stepped = 1;
                m_left  = DWELL;
            end
        end
    endtask

    task automatic model_request(input int lvl);
        int v;
        v = (lvl > MAXL) ? MAXL : lvl;
        if (!m_busy) begin
            m_tgt = v;
            if (v != m_flag) begin
                m_busy = 1; m_qual = 1; m_left = HOLD;
            end
        end else if (m_qual) begin
            if (v == m_flag) begin
                m_busy = 0; m_qual = 0; m_tgt = v;
            end else if (v != m_tgt) begin
                m_tgt = v; m_left = HOLD;
            end
        end else begin
            m_tgt = v;
            if (m_left == 0 && v == m_flag) m_busy = 0;
        end
    endtask

    task automatic model_disable();
        m_tgt = 0;
        if (!m_busy || m_qual) begin
            m_qual = 0;
            if (m_flag != 0) begin
                m_busy = 1; m_left = 0;
            end else begin
                m_busy = 0;
            end
        end else if (m_left == 0 && m_flag == 0) begin
            m_busy = 0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; freq_valid = 1'b0; freq_level = '0; frame_start = 1'b0;
        cycles(2);
        checks++; if (freq_flag !== 3'd0) begin fails++; $display("FAIL reset_flag: got %0d expected 0", freq_flag); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (level_changed !== 1'b0) begin fails++; $display("FAIL reset_lc: got %b expected 0", level_changed); end
        reset = 1'b0;
        frame(1);
        checks++; if (freq_flag !== 3'd0 || busy !== 1'b0) begin fails++; $display("FAIL reset_idle: got flag %0d busy %b expected 0 0", freq_flag, busy); end
    endtask

    task automatic test_ramp_up();
        int lc0, exp_flag;
        do_reset();
        enable = 1'b1;
        lc0 = lc_count;
        request(3'd3);
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL ramp_qual_busy: got %b expected 1", busy); end
        for (int f = 1; f <= 8; f++) begin
            frame(1);
            exp_flag = (f < 3) ? 0 : (f - 1) / 2;
            checks++; if (freq_flag !== 3'(exp_flag)) begin fails++; $display("FAIL ramp_flag F%0d: got %0d expected %0d", f, freq_flag, exp_flag); end
            checks++; if (busy !== (f < 8)) begin fails++; $display("FAIL ramp_busy F%0d: got %b expected %b", f, busy, f < 8); end
        end
        checks++; if (lc_count - lc0 != 3) begin fails++; $display("FAIL ramp_pulses: got %0d expected 3", lc_count - lc0); end
    endtask

    task automatic test_enable_drop();
        int lc0, exp_flag;
        lc0 = lc_count;
        @(negedge clk);
        enable = 1'b0;
        cycles(2);
        checks++; if (busy !== 1'b1 || freq_flag !== 3'd3) begin fails++; $display("FAIL drop_start: got flag %0d busy %b expected 3 1", freq_flag, busy); end
        for (int f = 1; f <= 6; f++) begin
            frame(1);
            if (f == 1) request(3'd4);
            exp_flag = 3 - (f + 1) / 2;
            checks++; if (freq_flag !== 3'(exp_flag)) begin fails++; $display("FAIL drop_flag F%0d: got %0d expected %0d", f, freq_flag, exp_flag); end
            checks++; if (busy !== (f < 6)) begin fails++; $display("FAIL drop_busy F%0d: got %b expected %b", f, busy, f < 6); end
        end
        checks++; if (lc_count - lc0 != 3) begin fails++; $display("FAIL drop_pulses: got %0d expected 3", lc_count - lc0); end
        enable = 1'b1;
        frame(1);
        frame(1);
        checks++; if (freq_flag !== 3'd0 || busy !== 1'b0) begin fails++; $display("FAIL reenable_idle: got flag %0d busy %b expected 0 0", freq_flag, busy); end
    endtask

    task automatic test_debounce();
        int exp_flag;
        do_reset();
        enable = 1'b1;
        request(3'd2);
        frame(1);
        request(3'd4);
        for (int f = 1; f <= 10; f++) begin
            frame(1);
            exp_flag = (f < 3) ? 0 : (f - 1) / 2;
            checks++; if (freq_flag !== 3'(exp_flag)) begin fails++; $display("FAIL debounce_flag F%0d: got %0d expected %0d", f, freq_flag, exp_flag); end
            checks++; if (busy !== (f < 10)) begin fails++; $display("FAIL debounce_busy F%0d: got %b expected %b", f, busy, f < 10); end
        end
    endtask

    task automatic test_glitch_cancel();
        int lc0;
        do_reset();
        enable = 1'b1;
        lc0 = lc_count;
        request(3'd2);
        frame(1);
        request(3'd0);
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL glitch_busy: got %b expected 0", busy); end
        repeat (4) frame(1);
        checks++; if (freq_flag !== 3'd0 || busy !== 1'b0) begin fails++; $display("FAIL glitch_idle: got flag %0d busy %b expected 0 0", freq_flag, busy); end
        checks++; if (lc_count != lc0) begin fails++; $display("FAIL glitch_pulses: got %0d expected 0", lc_count - lc0); end
    endtask

    task automatic test_clamp_simul();
        int exp_flag;
        do_reset();
        enable = 1'b1;
        @(negedge clk);
        freq_valid = 1'b1; freq_level = 3'd7; frame_start = 1'b1;
        @(negedge clk);
        freq_valid = 1'b0; frame_start = 1'b0;
        cycles(3);
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL clamp_busy: got %b expected 1", busy); end
        for (int f = 1; f <= 10; f++) begin
            frame(1);
            exp_flag = (f < 3) ? 0 : (f - 1) / 2;
            checks++; if (freq_flag !== 3'(exp_flag)) begin fails++; $display("FAIL clamp_flag F%0d: got %0d expected %0d", f, freq_flag, exp_flag); end
        end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL clamp_end_busy: got %b expected 0", busy); end
    endtask

    task automatic test_held_frame();
        do_reset();
        enable = 1'b1;
        request(3'd1);
        frame(3);
        frame(3);
        checks++; if (freq_flag !== 3'd0) begin fails++; $display("FAIL held_flag2: got %0d expected 0", freq_flag); end
        frame(3);
        checks++; if (freq_flag !== 3'd1) begin fails++; $display("FAIL held_flag3: got %0d expected 1", freq_flag); end
    endtask

    task automatic test_async_reset();
        int lc0;
        do_reset();
        enable = 1'b1;
        request(3'd4);
        repeat (5) frame(1);
        checks++; if (freq_flag !== 3'd2 || busy !== 1'b1) begin fails++; $display("FAIL areset_pre: got flag %0d busy %b expected 2 1", freq_flag, busy); end
        lc0 = lc_count;
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        checks++; if (freq_flag !== 3'd0 || busy !== 1'b0) begin fails++; $display("FAIL areset_now: got flag %0d busy %b expected 0 0", freq_flag, busy); end
        checks++; if (level_changed !== 1'b0) begin fails++; $display("FAIL areset_lc: got %b expected 0", level_changed); end
        frame(1);
        reset = 1'b0;
        cycles(3);
        frame(1);
        checks++; if (lc_count != lc0 || freq_flag !== 3'd0 || busy !== 1'b0) begin fails++; $display("FAIL areset_after: got pulses %0d flag %0d busy %b expected 0 0 0", lc_count - lc0, freq_flag, busy); end
    endtask

    task automatic test_random();
        int hi, r, lvl, stepped, lc0;
        do_reset();
        enable = 1'b1;
        m_flag = 0; m_tgt = 0; m_left = 0; m_busy = 0; m_qual = 0;
        for (int s = 0; s < 250; s++) begin
            hi  = $urandom_range(1, 2);
            lc0 = lc_count;
            @(negedge clk);
            frame_start = 1'b1;
            model_frame(stepped);
            repeat (hi) @(negedge clk);
            frame_start = 1'b0;
            repeat (3 - hi) @(negedge clk);
            r = $urandom_range(0, 99);
            if (r < 40) begin
                lvl = $urandom_range(0, 7);
                freq_valid = 1'b1;
                freq_level = 3'(lvl);
                if (enable) model_request(lvl);
            end else if (r < 52) begin
                enable = ~enable;
                if (!enable) model_disable();
            end
            @(negedge clk);
            freq_valid = 1'b0;
            repeat (2) @(negedge clk);
            checks++; if (freq_flag !== 3'(m_flag)) begin fails++; $display("FAIL rand_flag slot %0d: got %0d expected %0d", s, freq_flag, m_flag); end
            checks++; if (busy !== m_busy) begin fails++; $display("FAIL rand_busy slot %0d: got %b expected %b", s, busy, m_busy); end
            checks++; if (lc_count - lc0 != stepped) begin fails++; $display("FAIL rand_pulses slot %0d: got %0d expected %0d", s, lc_count - lc0, stepped); end
        end
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_enable_drop();
        test_debounce();
        test_glitch_cancel();
        test_clamp_simul();
        test_held_frame();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
